// File: rtl/instr_realigner.sv
// -----------------------------------------------------------------------------
// instr_realigner
//
// Fetch-side halfword realigner that sits in front of the C-extension
// decompressor. It takes 32-bit aligned words from instruction memory and hands
// out one instruction per output handshake, together with its byte PC and an
// is_compressed flag. It rebuilds 32-bit instructions that straddle a word
// boundary and silently drops words that arrive for an address it no longer
// expects, for example words still in flight after a redirect.
//
// Ports
//   clk                in   1   system clock, all state changes on rising edge
//   reset              in   1   asynchronous, active-high reset
//   flush              in   1   redirect: discard everything held, restart at flush_pc
//   flush_pc           in   32  new halfword-aligned PC (bit 1 may be set)
//   in_valid           in   1   in_word / in_addr are valid
//   in_ready           out  1   word is accepted this cycle (may follow out_ready)
//   in_word            in   32  little-endian instruction word
//   in_addr            in   32  byte address of in_word, [1:0] = 0
//   out_valid          out  1   out_* hold an instruction
//   out_ready          in   1   downstream accepts the instruction
//   out_instr          out  32  raw instruction, [31:16] = 0 when compressed
//   out_pc             out  32  byte address of out_instr
//   out_is_compressed  out  1   out_instr[1:0] != 2'b11
//
// State meaning
//   EMPTY : no word held, waiting for the word at exp_addr
//   LO    : current instruction starts at word_q[15:0]
//   HI    : current instruction starts at word_q[31:16]
//   SPLIT : upper halfword of a straddling 32-bit instruction saved in hw_q,
//           waiting for the word that carries its second half
//   SPAN  : presenting {word_q[15:0], hw_q}; the upper half of word_q is next
// -----------------------------------------------------------------------------
module instr_realigner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic [31:0] in_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_compressed
);

    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_SPLIT = 3'd3,
        S_SPAN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [15:0] hw_q, hw_d;
    logic [29:0] exp_addr_q, exp_addr_d;
    logic [31:0] pc_q, pc_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_comp_q, out_comp_d;

    logic        out_fire;
    logic        word_hit;
    logic        lo_comp;
    logic        hi_comp;

    // Word-offset bits of in_addr carry no information (always zero).
    logic        unused_addr_bits;
    assign unused_addr_bits = ^in_addr[1:0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        hw_d       = hw_q;
        exp_addr_d = exp_addr_q;
        pc_d       = pc_q;
        in_ready   = 1'b0;

        out_fire = out_valid_q && out_ready;
        // A word only counts when it is the one we are waiting for; anything
        // else that is accepted is simply consumed and thrown away.
        word_hit = in_valid && (in_addr[31:2] == exp_addr_q);
        lo_comp  = (word_q[1:0] != 2'b11);
        hi_comp  = (word_q[17:16] != 2'b11);

        unique case (state_q)
            S_EMPTY: begin
                in_ready = 1'b1;
                if (word_hit) begin
                    word_d     = in_word;
                    exp_addr_d = exp_addr_q + 30'd1;
                    state_d    = pc_q[1] ? S_HI : S_LO;
                end
            end

            S_LO: begin
                if (lo_comp) begin
                    // Upper half of the same word is still pending, so no
                    // new word can be taken yet.
                    if (out_fire) begin
                        pc_d    = pc_q + 32'd2;
                        state_d = S_HI;
                    end
                end else begin
                    // The whole word is consumed by this instruction, so the
                    // next word may be loaded in the very same cycle.
                    in_ready = out_ready;
                    if (out_fire) begin
                        pc_d = pc_q + 32'd4;
                        if (word_hit) begin
                            word_d     = in_word;
                            exp_addr_d = exp_addr_q + 30'd1;
                            state_d    = S_LO;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end
            end

            S_HI: begin
                if (hi_comp) begin
                    in_ready = out_ready;
                    if (out_fire) begin
                        pc_d = pc_q + 32'd2;
                        if (word_hit) begin
                            word_d     = in_word;
                            exp_addr_d = exp_addr_q + 30'd1;
                            state_d    = S_LO;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end else begin
                    // First half of a straddling 32-bit instruction: park it
                    // and free word_q for the following word.
                    hw_d    = word_q[31:16];
                    state_d = S_SPLIT;
                end
            end

            S_SPLIT: begin
                in_ready = 1'b1;
                if (word_hit) begin
                    word_d     = in_word;
                    exp_addr_d = exp_addr_q + 30'd1;
                    state_d    = S_SPAN;
                end
            end

            S_SPAN: begin
                // word_q[31:16] is still unconsumed, so no refill here.
                if (out_fire) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_HI;
                end
            end

            default: begin
                state_d = S_EMPTY;
            end
        endcase

        // A redirect overrides everything that happened above this cycle,
        // including any input or output handshake.
        if (flush) begin
            state_d    = S_EMPTY;
            pc_d       = flush_pc;
            exp_addr_d = flush_pc[31:2];
        end
    end

    // -------------------------------------------------------------------------
    // Output view of the next state. The outputs are registered copies of this
    // so that out_* never depend combinationally on the inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d = 1'b0;
        out_instr_d = 32'h0;
        out_pc_d    = 32'h0;
        out_comp_d  = 1'b0;

        unique case (state_d)
            S_LO: begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_d;
                if (word_d[1:0] != 2'b11) begin
                    out_comp_d  = 1'b1;
                    out_instr_d = {16'h0, word_d[15:0]};
                end else begin
                    out_instr_d = word_d;
                end
            end

            S_HI: begin
                // A 32-bit instruction starting here is not presentable yet;
                // it moves on to SPLIT on the following edge.
                if (word_d[17:16] != 2'b11) begin
                    out_valid_d = 1'b1;
                    out_comp_d  = 1'b1;
                    out_pc_d    = pc_d;
                    out_instr_d = {16'h0, word_d[31:16]};
                end
            end

            S_SPAN: begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_d;
                out_instr_d = {word_d[15:0], hw_d};
                out_comp_d  = (hw_d[1:0] != 2'b11);
            end

            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            word_q     <= 32'h0;
            hw_q       <= 16'h0;
            exp_addr_q <= RESET_PC[31:2];
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            hw_q       <= hw_d;
            exp_addr_q <= exp_addr_d;
            pc_q       <= pc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc_q    <= 32'h0;
            out_comp_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_comp_q  <= out_comp_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_instr         = out_instr_q;
    assign out_pc            = out_pc_q;
    assign out_is_compressed = out_comp_q;

endmodule

// File: tb/tb_instr_realigner.sv
// Testbench for instr_realigner: directed table-driven scenarios followed by a
// randomized run checked against a halfword-stream reference model.
module tb_instr_realigner;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_compressed;

    instr_realigner #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_word           (in_word),
        .in_addr           (in_addr),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .out_pc            (out_pc),
        .out_is_compressed (out_is_compressed)
    );

    typedef struct {logic [31:0] addr; logic [31:0] word;} feed_t;
    typedef struct {logic [31:0] instr; logic [31:0] pc; logic comp;} vec_t;
    typedef struct {logic [31:0] addr; logic [15:0] h;} hw_t;
    typedef struct {logic [31:0] instr; logic [31:0] pc; logic comp; int cyc;} got_t;

    feed_t dfeed[20];
    vec_t  vec[22];

    feed_t feed_q[$];   // words waiting to be offered to the DUT
    hw_t   mq[$];       // reference model: halfwords not yet emitted
    got_t  got_q[$];    // instructions observed on the output

    logic [31:0] m_pc;
    logic [29:0] m_exp;

    int nchecks = 0;
    int nerrors = 0;
    int cyc = 0;
    int rand_outs = 0;
    logic count_rand = 1'b0;

    logic        prev_hold = 1'b0;
    logic [31:0] prev_instr, prev_pc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: the accepted word stream is a stream of halfwords with
    // addresses; each emitted instruction is taken from its head at m_pc.
    task automatic model_out();
        logic [15:0] h0;
        logic [31:0] e_instr;
        logic        e_comp;
        int          n;
        while (mq.size() > 0 && mq[0].addr != m_pc) void'(mq.pop_front());
        n = 0;
        e_instr = 32'h0;
        e_comp  = 1'b0;
        if (mq.size() > 0) begin
            h0 = mq[0].h;
            if (h0[1:0] != 2'b11) begin
                e_instr = {16'h0, h0};
                e_comp  = 1'b1;
                n = 1;
            end else if (mq.size() >= 2) begin
                e_instr = {mq[1].h, h0};
                n = 2;
            end
        end
        if (n == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL model_unexpected_out: got 0x%08h at 0x%08h, model has no complete instruction at 0x%08h",
                     out_instr, out_pc, m_pc);
        end else begin
            check("model_instr", out_instr, e_instr);
            check("model_pc", out_pc, m_pc);
            check("model_comp", {31'b0, out_is_compressed}, {31'b0, e_comp});
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            m_pc = m_pc + 32'(2 * n);
        end
    endtask

    // Monitor: everything is sampled on the falling edge, where inputs and
    // outputs are stable ahead of the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            m_pc      = 32'h0;
            m_exp     = 30'h0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_instr", out_instr, prev_instr);
                check("hold_pc", out_pc, prev_pc);
            end
            prev_hold  = out_valid && !out_ready && !flush;
            prev_instr = out_instr;
            prev_pc    = out_pc;

            if (in_valid && in_ready && feed_q.size() > 0) void'(feed_q.pop_front());

            if (flush) begin
                mq.delete();
                m_pc  = flush_pc;
                m_exp = flush_pc[31:2];
            end else begin
                if (out_valid && out_ready) begin
                    got_q.push_back('{out_instr, out_pc, out_is_compressed, cyc});
                    if (count_rand) rand_outs++;
                    model_out();
                end
                if (in_valid && in_ready && in_addr[31:2] == m_exp) begin
                    mq.push_back('{in_addr, in_word[15:0]});
                    mq.push_back('{in_addr + 32'd2, in_word[31:16]});
                    m_exp = m_exp + 30'd1;
                end
                while (mq.size() > 0 && mq[0].addr != m_pc) void'(mq.pop_front());
                check("model_occupancy_le3", {31'b0, mq.size() <= 3}, 32'd1);
            end
        end
    end

    // Input driver: offers the head of feed_q just after each rising edge.
    initial begin
        in_valid = 1'b0;
        in_addr  = 32'h0;
        in_word  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (feed_q.size() > 0) begin
                in_valid = 1'b1;
                in_addr  = feed_q[0].addr;
                in_word  = feed_q[0].word;
            end else begin
                in_valid = 1'b0;
                in_addr  = 32'h0;
                in_word  = 32'h0;
            end
        end
    end

    task automatic do_flush(input logic [31:0] pc);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk);
        #1;
        flush = 1'b0;
        got_q.delete();
    endtask

    task automatic push_feeds(input int first, input int n);
        for (int i = 0; i < n; i++) feed_q.push_back(dfeed[first + i]);
    endtask

    task automatic expect_outputs(input int first, input int n, input string tag);
        int budget;
        budget = 200;
        while (got_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check({tag, "_instr"}, got_q[i].instr, vec[first + i].instr);
            check({tag, "_pc"}, got_q[i].pc, vec[first + i].pc);
            check({tag, "_comp"}, {31'b0, got_q[i].comp}, {31'b0, vec[first + i].comp});
        end
    endtask

    initial begin
        int          b;
        logic [31:0] next_feed;
        logic [31:0] fpc;

        // Directed input words.
        dfeed[0]  = '{32'h0000_0000, 32'h0505_4501};  // all compressed
        dfeed[1]  = '{32'h0000_0000, 32'h0513_4501};  // straddle
        dfeed[2]  = '{32'h0000_0004, 32'h0000_0005};
        dfeed[3]  = '{32'h0000_0000, 32'h0513_0000};  // back-pressure in SPAN
        dfeed[4]  = '{32'h0000_0004, 32'h1111_0005};
        dfeed[5]  = '{32'h0000_0008, 32'h0001_0002};
        dfeed[6]  = '{32'h0000_0008, 32'h1234_5678};  // stale after flush
        dfeed[7]  = '{32'h0000_000C, 32'h9ABC_DEF3};  // stale after flush
        dfeed[8]  = '{32'h0000_0100, 32'hABCD_0001};
        dfeed[9]  = '{32'h0000_0104, 32'h0000_0009};
        for (int i = 0; i < 8; i++)
            dfeed[10 + i] = '{32'h0000_0200 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 7)};
        dfeed[18] = '{32'h0000_0000, 32'h0513_0000};  // reaches SPLIT, then reset
        dfeed[19] = '{32'h0000_0000, 32'h0505_4501};  // restart after reset

        // Expected instructions.
        vec[0]  = '{32'h0000_4501, 32'h0000_0000, 1'b1};
        vec[1]  = '{32'h0000_0505, 32'h0000_0002, 1'b1};
        vec[2]  = '{32'h0000_4501, 32'h0000_0000, 1'b1};
        vec[3]  = '{32'h0005_0513, 32'h0000_0002, 1'b0};
        vec[4]  = '{32'h0000_0000, 32'h0000_0006, 1'b1};
        vec[5]  = '{32'h0005_0513, 32'h0000_0002, 1'b0};
        vec[6]  = '{32'h0000_1111, 32'h0000_0006, 1'b1};
        vec[7]  = '{32'h0000_0002, 32'h0000_0008, 1'b1};
        vec[8]  = '{32'h0000_0001, 32'h0000_000A, 1'b1};
        vec[9]  = '{32'h0000_ABCD, 32'h0000_0102, 1'b1};
        vec[10] = '{32'h0000_0009, 32'h0000_0104, 1'b1};
        vec[11] = '{32'h0000_0000, 32'h0000_0106, 1'b1};
        for (int i = 0; i < 8; i++)
            vec[12 + i] = '{32'h0000_0013 | (32'(i) << 7), 32'h0000_0200 + 32'(4 * i), 1'b0};
        vec[20] = '{32'h0000_4501, 32'h0000_0000, 1'b1};
        vec[21] = '{32'h0000_0505, 32'h0000_0002, 1'b1};

        reset     = 1'b0;
        flush     = 1'b0;
        flush_pc  = 32'h0;
        out_ready = 1'b1;
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);

        // Reset values.
        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_instr", out_instr, 32'h0);
        check("reset_out_pc", out_pc, 32'h0);
        check("reset_out_comp", {31'b0, out_is_compressed}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // All compressed.
        got_q.delete();
        push_feeds(0, 1);
        expect_outputs(0, 2, "allc");

        // Straddling 32-bit instruction.
        do_flush(32'h0000_0000);
        push_feeds(1, 2);
        expect_outputs(2, 3, "straddle");

        // Back-pressure while presenting a straddled instruction.
        out_ready = 1'b0;
        do_flush(32'h0000_0002);
        push_feeds(3, 3);
        b = 0;
        while (!out_valid && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("bp_reached_valid", {31'b0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_instr", out_instr, 32'h0005_0513);
            check("bp_pc", out_pc, 32'h0000_0002);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_word_kept", feed_q.size(), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_outputs(5, 4, "bp");

        // Redirect while stale words are still arriving.
        do_flush(32'h0000_0102);
        push_feeds(6, 4);
        expect_outputs(9, 3, "flush");

        // Aligned 32-bit stream, one instruction per cycle.
        do_flush(32'h0000_0200);
        push_feeds(10, 8);
        expect_outputs(12, 8, "stream");
        for (int i = 1; i < 8 && i < got_q.size(); i++)
            check("stream_cycle_gap", got_q[i].cyc - got_q[i - 1].cyc, 32'd1);

        // Reset asserted while in SPLIT.
        do_flush(32'h0000_0002);
        push_feeds(18, 1);
        b = 0;
        while (feed_q.size() != 0 && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("split_word_taken", feed_q.size(), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_split_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_split_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_split_out_pc", out_pc, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        push_feeds(19, 1);
        expect_outputs(20, 2, "rst_restart");

        // Randomized traffic, starting just below the address wrap.
        do_flush(32'hFFFF_FF02);
        next_feed  = 32'hFFFF_FF00;
        count_rand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (c > 400 && $urandom_range(0, 99) == 0) begin
                fpc      = 32'h0000_3000 + (32'($urandom_range(0, 255)) << 1);
                flush    = 1'b1;
                flush_pc = fpc;
                next_feed = fpc & ~32'h3;
            end else begin
                flush = 1'b0;
                if (feed_q.size() < 3 && $urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 7) == 0) begin
                        feed_q.push_back('{next_feed + 32'h40, $urandom});
                    end else begin
                        feed_q.push_back('{next_feed, $urandom});
                        next_feed = next_feed + 32'd4;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        count_rand = 1'b0;
        check("rand_progress", {31'b0, rand_outs > 200}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
